stereo_feed_arbiter: RTL
========================

Name: stereo_feed_arbiter

Overview:
- Shares one pixel-encryption engine between the left and right camera pixel streams.
- Grants the engine in fixed-length bursts and alternates round-robin between sides.
- Tracks beats with an internal up-counter that wraps at BURST_LEN-1.
- Sits between the two capture front-ends and the encryption core; tags each beat with its source side and marks the last beat of each burst.

Parameters:
DATA_WIDTH, 24, pixel word width (RGB888).
BURST_LEN, 16, beats per grant; legal range 1..2^COUNT_WIDTH.
COUNT_WIDTH, 5, burst beat counter width.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset.
l_valid  input  1  left stream has a pixel.
l_data  input  DATA_WIDTH  left pixel.
l_ready  output  1  left pixel accepted this cycle.
r_valid  input  1  right stream has a pixel.
r_data  input  DATA_WIDTH  right pixel.
r_ready  output  1  right pixel accepted this cycle.
enc_valid  output  1  pixel presented to the encryption core.
enc_data  output  DATA_WIDTH  pixel to the core.
enc_sel  output  1  source of the current beat: 0=left, 1=right.
enc_last  output  1  current beat is the final beat of the burst.
enc_ready  input  1  core accepts the pixel.
busy  output  1  a burst is in progress (state not IDLE).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, beat counter=0, last_served=1 (right), so left wins the first tie.
  - All outputs 0 while reset is low and in IDLE.
- States:
  - IDLE: no grant; enc_valid=0, l_ready=r_ready=0.
  - GRANT_L: enc_valid=l_valid, enc_data=l_data, enc_sel=0, l_ready=enc_ready, r_ready=0.
  - GRANT_R: mirror of GRANT_L with enc_sel=1.
- Datapath: combinational mux from the granted side. Zero-cycle data latency inside a burst.
- Grant latency: one cycle from a request seen in IDLE to the GRANT state.
- Beat: enc_valid & enc_ready.
  - Counter increments on each beat.
  - enc_last = beat-qualified-free flag (counter==BURST_LEN-1) while granted.
  - On the last beat the counter wraps to 0.
- Bursts are non-preemptive. If the granted side drops valid mid-burst, the grant is held and the counter holds (stall).
- Transitions:
  - IDLE -> GRANT_L if l_valid & (!r_valid | last_served==1).
  - IDLE -> GRANT_R if r_valid & (!l_valid | last_served==0).
  - IDLE stays IDLE if neither side requests.
- End of burst (last beat), in GRANT_L:
  - last_served<=0.
  - Go to GRANT_R if r_valid; else stay in GRANT_L (new burst) if l_valid; else go to IDLE.
  - GRANT_R is symmetric.
  - Valids are sampled in the last-beat cycle. Switching sides costs no bubble cycle.
- BURST_LEN=1: every beat is last; sides alternate per beat when both request.
- The counter never exceeds BURST_LEN-1. Counter compare uses COUNT_WIDTH bits.
- Reset mid-burst: the burst is abandoned immediately. The core sees enc_valid fall with no enc_last.
- Upstream streams must hold valid/data stable until ready (standard valid/ready rule). The arbiter never drops or duplicates a beat.

Optional Feature:
- Macro: BURST_TIMEOUT_EN.
- Defined:
  - Adds parameter TIMEOUT_CYCLES (default 64) and output timeout_abort (1 bit).
  - While granted, an idle counter increments on each cycle with the granted valid=0 and clears on any beat.
  - Reaching TIMEOUT_CYCLES ends the burst early: timeout_abort pulses high for one cycle, the beat counter resets to 0, and the normal end-of-burst transition applies.
  - No enc_last is issued for an aborted burst.
- Undefined: no timeout logic and no timeout_abort port; a stalled burst waits indefinitely.

Test Plan:
1. Reset release, l_valid=1, r_valid=0, enc_ready=1, BURST_LEN=16 -> GRANT_L on cycle 1. 16 beats with enc_sel=0, enc_last on beat 16, then the next left burst with no bubble.
2. Both valid continuously, enc_ready=1 -> bursts alternate L,R,L with 16 beats each. First burst is left. enc_sel toggles exactly after each enc_last.
3. Left granted, enc_ready low for 5 cycles at beat 7 -> counter holds at 7, l_ready=0, no beats lost. Burst completes after 16 accepted beats.
4. Left drops valid at beat 10 while r_valid=1 -> grant stays left. Right is not served until left supplies the remaining 6 beats.
5. reset asserted at beat 9 of a right burst -> outputs go to 0 asynchronously. After release with both valid, the left side is granted first and the counter restarts at 0.
6. With BURST_TIMEOUT_EN and TIMEOUT_CYCLES=64: granted side idle for 64 cycles at beat 3, r_valid=1 -> timeout_abort pulses once, GRANT_R follows, and there is no enc_last for the aborted burst.

Source files
------------

// File: rtl/stereo_feed_arbiter.sv
// stereo_feed_arbiter
//   Shares one pixel-encryption engine between the left and right camera
//   streams. The engine is granted in fixed-length bursts of BURST_LEN beats.
//   When both sides are requesting, grants alternate round-robin. The data
//   path is a zero-latency combinational mux from the granted side.
//
//   Optional build macro: BURST_TIMEOUT_EN
//     Adds parameter TIMEOUT_CYCLES and output timeout_abort. A burst whose
//     granted side presents no data for TIMEOUT_CYCLES cycles is ended early.
//
// Ports
//   clk, reset        clock; asynchronous active-low reset
//   l_valid/l_data    left pixel stream in;  l_ready accepts it
//   r_valid/r_data    right pixel stream in; r_ready accepts it
//   enc_valid/enc_data pixel presented to the encryption core
//   enc_sel           beat source (0 = left, 1 = right)
//   enc_last          current beat is the final beat of the burst
//   enc_ready         core accepts the pixel
//   busy              a burst is in progress
//   timeout_abort     (BURST_TIMEOUT_EN only) one-cycle early-abort pulse
module stereo_feed_arbiter #(
  parameter int unsigned DATA_WIDTH     = 24,
  parameter int unsigned BURST_LEN      = 16,
  parameter int unsigned COUNT_WIDTH    = 5
`ifdef BURST_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  l_valid,
  input  logic [DATA_WIDTH-1:0] l_data,
  output logic                  l_ready,
  input  logic                  r_valid,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_ready,
  output logic                  enc_valid,
  output logic [DATA_WIDTH-1:0] enc_data,
  output logic                  enc_sel,
  output logic                  enc_last,
  input  logic                  enc_ready,
  output logic                  busy
`ifdef BURST_TIMEOUT_EN
  ,
  output logic                  timeout_abort
`endif
);

  localparam logic [COUNT_WIDTH-1:0] LAST_CNT = COUNT_WIDTH'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_L = 2'd1,
    GRANT_R = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   last_served_q, last_served_d;

  logic gnt_valid;
  logic beat;
  logic at_last;
  logic abort;
  logic burst_end;

  always_comb begin
    gnt_valid = 1'b0;
    case (state_q)
      GRANT_L: gnt_valid = l_valid;
      GRANT_R: gnt_valid = r_valid;
      default: gnt_valid = 1'b0;
    endcase
  end

  assign beat    = gnt_valid & enc_ready;
  // Position flag only; it is not qualified by valid/ready.
  assign at_last = (state_q != IDLE) && (cnt_q == LAST_CNT);

`ifdef BURST_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [IDLE_W-1:0] idle_q, idle_d;

  // The abort fires in the cycle that would be the TIMEOUT_CYCLES-th
  // consecutive empty cycle, so that cycle already takes the end-of-burst
  // transition.
  assign abort         = (state_q != IDLE) && !gnt_valid && (idle_q == IDLE_LIMIT);
  assign timeout_abort = abort;

  always_comb begin
    idle_d = idle_q;
    if (state_q == IDLE || beat || abort) begin
      idle_d = '0;
    end else if (!gnt_valid) begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign abort = 1'b0;
`endif

  assign burst_end = (beat && at_last) || abort;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      last_served_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_served_q <= last_served_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_served_d = last_served_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (l_valid && (!r_valid || last_served_q)) begin
          state_d = GRANT_L;
        end else if (r_valid && (!l_valid || !last_served_q)) begin
          state_d = GRANT_R;
        end
      end
      GRANT_L: begin
        if (burst_end) begin
          cnt_d         = '0;
          last_served_d = 1'b0;
          if (r_valid) begin
            state_d = GRANT_R;
          end else if (l_valid) begin
            state_d = GRANT_L;
          end else begin
            state_d = IDLE;
          end
        end else if (beat) begin
          cnt_d = cnt_q + COUNT_WIDTH'(1);
        end
      end
      GRANT_R: begin
        if (burst_end) begin
          cnt_d         = '0;
          last_served_d = 1'b1;
          if (l_valid) begin
            state_d = GRANT_L;
          end else if (r_valid) begin
            state_d = GRANT_R;
          end else begin
            state_d = IDLE;
          end
        end else if (beat) begin
          cnt_d = cnt_q + COUNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    l_ready   = 1'b0;
    r_ready   = 1'b0;
    enc_valid = 1'b0;
    enc_data  = '0;
    enc_sel   = 1'b0;
    enc_last  = 1'b0;
    busy      = 1'b0;
    case (state_q)
      GRANT_L: begin
        busy      = 1'b1;
        enc_valid = l_valid;
        enc_data  = l_data;
        enc_sel   = 1'b0;
        enc_last  = at_last && !abort;
        l_ready   = enc_ready;
      end
      GRANT_R: begin
        busy      = 1'b1;
        enc_valid = r_valid;
        enc_data  = r_data;
        enc_sel   = 1'b1;
        enc_last  = at_last && !abort;
        r_ready   = enc_ready;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule
